uart_receive: RTL

- Serial-to-parallel UART receiver; the stage directly downstream of the team's UART transmitter, consuming its `tx` line.
- Frame format is fixed: idle high, one start bit (0), D_WIDTH data bits LSB first, one or more stop bits (1).
- Synchronises the line, detects and validates start bits, and shifts in data.
- Checks the stop bit and presents each good word on a one-entry valid/ready holding register, flagging framing errors and overruns.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync.sv | 31 +++
 rtl/uart_receive.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and line-level constants.
// The transmitter imports this package too.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } uart_state_e;

    localparam int unsigned DEF_D_WIDTH = 4;
    localparam logic        START_BIT   = 1'b0;
    localparam logic        STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// N-stage synchroniser for an idle-high line. Flops reset to 1.
// SYNC_STAGES=0 passes the input straight through.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (SYNC_STAGES == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_flops
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '1;
            end else begin
                sync_q[0] <= d_i;
                for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign q_o = sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start-bit validation, LSB-first shift-in, stop-bit check,
// and a one-entry valid/ready holding register with framing/overrun pulses.
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned D_WIDTH      = DEF_D_WIDTH,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BW   = $clog2(D_WIDTH + 1);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [BW-1:0] LAST_BIT = BW'(D_WIDTH - 1);

    logic rx_s;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    uart_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [D_WIDTH-1:0] shift_q, shift_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) begin
                    if (HALF == 0) begin
                        state_d = DATA;
                        cnt_d   = CNT_BIT;
                        bit_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_HALF;
                    end
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = CNT_BIT;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // shift right with the new bit entering at the MSB
                    shift_d = D_WIDTH'({rx_s, shift_q} >> 1);
                    cnt_d   = CNT_BIT;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rx_s == STOP_BIT) begin
                    state_d = IDLE;
                    if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = valid_q;
                        ovr_d   = 1'b1;
                    end
                end else begin
                    state_d = BRK;
                    ferr_d  = 1'b1;
                end
            end
            BRK: begin
                if (rx_s == STOP_BIT) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
